// File: rtl/smp_io_pkg.sv
// Shared definitions for the SPC700 $00F0-$00FF I/O register block:
// register offsets, CONTROL bit positions and the per-timer state.
package smp_io_pkg;
    localparam logic [3:0] CTRL    = 4'h1;
    localparam logic [3:0] DSPADDR = 4'h2;
    localparam logic [3:0] DSPDATA = 4'h3;
    localparam logic [3:0] CPU0    = 4'h4;
    localparam logic [3:0] CPU1    = 4'h5;
    localparam logic [3:0] CPU2    = 4'h6;
    localparam logic [3:0] CPU3    = 4'h7;
    localparam logic [3:0] AUX0    = 4'h8;
    localparam logic [3:0] AUX1    = 4'h9;
    localparam logic [3:0] T0DIV   = 4'hA;
    localparam logic [3:0] T1DIV   = 4'hB;
    localparam logic [3:0] T2DIV   = 4'hC;
    localparam logic [3:0] T0OUT   = 4'hD;
    localparam logic [3:0] T1OUT   = 4'hE;
    localparam logic [3:0] T2OUT   = 4'hF;

    localparam int CTRL_CLR01 = 4;
    localparam int CTRL_CLR23 = 5;
    localparam int CTRL_IPL   = 7;

    localparam int NUM_TIMERS = 3;

    typedef struct packed {
        logic [7:0] cnt2;
        logic [3:0] cnt3;
    } timer_state_t;
endpackage

// File: rtl/smp_timer.sv
// One timer: 8-bit stage-2 divider against a programmable limit (0 means 256)
// feeding a 4-bit read-to-clear stage-3 counter.
module smp_timer
    import smp_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       en,
    input  logic [7:0] div,
    input  logic       rd_clr,
    input  logic       restart,
    output logic [3:0] cnt3
);
    timer_state_t st;
    logic [8:0]   nxt2;
    logic [8:0]   lim;
    logic         hit;

    // 9-bit compare so a limit of 256 matches the 255->0 wrap, while any
    // smaller limit already passed just wraps through without a hit.
    always_comb begin
        nxt2 = {1'b0, st.cnt2} + 9'd1;
        lim  = (div == 8'd0) ? 9'd256 : {1'b0, div};
        hit  = tick & en & (nxt2 == lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= '0;
        end else if (restart) begin
            st <= '0;
        end else begin
            if (tick & en)
                st.cnt2 <= hit ? 8'd0 : nxt2[7:0];
            // A clear coinciding with an increment keeps the new tick.
            if (hit)
                st.cnt3 <= (rd_clr ? 4'd0 : st.cnt3) + 4'd1;
            else if (rd_clr)
                st.cnt3 <= 4'd0;
        end
    end

    assign cnt3 = st.cnt3;
endmodule

// File: rtl/smp_io_regs.sv
// SPC700 I/O registers at $00F0-$00FF: CONTROL, DSP window, host mailboxes,
// aux bytes and three prescaled timers; also drives the IPL ROM enable.
module smp_io_regs
    import smp_io_pkg::*;
#(
    parameter int T01_DIV = 128,
    parameter int T2_DIV  = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    input  logic        WE_N,
    output logic        IO_SEL,
    output logic [7:0]  D_OUT,
    output logic        IPL_EN,
    output logic [7:0]  DSP_ADDR,
    input  logic [7:0]  DSP_DIN,
    output logic        DSP_WE,
    output logic [7:0]  DSP_DOUT,
    input  logic        HOST_WR,
    input  logic [1:0]  HOST_ADDR,
    input  logic [7:0]  HOST_DIN,
    output logic [7:0]  HOST_DOUT
);
    localparam int W01 = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;
    localparam int W2  = (T2_DIV > 1) ? $clog2(T2_DIV) : 1;

    logic [3:0]            off;
    logic                  cpu_wr;
    logic [W01-1:0]        pre01;
    logic [W2-1:0]         pre2;
    logic                  tick01, tick2;
    logic [NUM_TIMERS-1:0] ten, rd_clr, restart;
    logic                  ipl;
    logic [3:0][7:0]       cpui, cpuo;
    logic [1:0][7:0]       aux;
    logic [NUM_TIMERS-1:0][7:0] tdiv;
    logic [NUM_TIMERS-1:0][3:0] cnt3;
    logic                  unused_bits;

    assign off         = A[3:0];
    assign IO_SEL      = (A[15:4] == 12'h00F);
    assign cpu_wr      = EN & ~WE_N & IO_SEL;
    assign tick01      = EN & (pre01 == W01'(T01_DIV - 1));
    assign tick2       = EN & (pre2 == W2'(T2_DIV - 1));
    assign IPL_EN      = ipl;
    assign HOST_DOUT   = cpuo[HOST_ADDR];
    assign unused_bits = ^{D_IN[6], D_IN[3]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pre01 <= '0;
            pre2  <= '0;
        end else if (EN) begin
            pre01 <= tick01 ? '0 : pre01 + W01'(1);
            pre2  <= tick2 ? '0 : pre2 + W2'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ten      <= '0;
            ipl      <= 1'b1;
            DSP_ADDR <= 8'h00;
            DSP_DOUT <= 8'h00;
            DSP_WE   <= 1'b0;
            cpui     <= '0;
            cpuo     <= '0;
            aux      <= '0;
            tdiv     <= '0;
        end else begin
            DSP_WE <= cpu_wr & (off == DSPDATA);
            if (HOST_WR)
                cpui[HOST_ADDR] <= HOST_DIN;
            // CONTROL mailbox clears come after the host write so they win.
            if (cpu_wr) begin
                case (off)
                    CTRL: begin
                        ten <= D_IN[NUM_TIMERS-1:0];
                        ipl <= D_IN[CTRL_IPL];
                        if (D_IN[CTRL_CLR01]) begin
                            cpui[0] <= 8'h00;
                            cpui[1] <= 8'h00;
                        end
                        if (D_IN[CTRL_CLR23]) begin
                            cpui[2] <= 8'h00;
                            cpui[3] <= 8'h00;
                        end
                    end
                    DSPADDR:                DSP_ADDR     <= D_IN;
                    DSPDATA:                DSP_DOUT     <= D_IN;
                    CPU0, CPU1, CPU2, CPU3: cpuo[off[1:0]] <= D_IN;
                    AUX0, AUX1:             aux[off[0]]  <= D_IN;
                    T0DIV:                  tdiv[0]      <= D_IN;
                    T1DIV:                  tdiv[1]      <= D_IN;
                    T2DIV:                  tdiv[2]      <= D_IN;
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
        assign rd_clr[i]  = EN & WE_N & IO_SEL & (off == T0OUT + 4'(i));
        assign restart[i] = cpu_wr & (off == CTRL) & D_IN[i] & ~ten[i];

        smp_timer u_tmr (
            .clk     (CLK),
            .rst_n   (RST_N),
            .tick    ((i == 2) ? tick2 : tick01),
            .en      (ten[i]),
            .div     (tdiv[i]),
            .rd_clr  (rd_clr[i]),
            .restart (restart[i]),
            .cnt3    (cnt3[i])
        );
    end

    always_comb begin
        D_OUT = 8'h00;
        if (IO_SEL) begin
            case (off)
                DSPADDR:                D_OUT = DSP_ADDR;
                DSPDATA:                D_OUT = DSP_DIN;
                CPU0, CPU1, CPU2, CPU3: D_OUT = cpui[off[1:0]];
                AUX0, AUX1:             D_OUT = aux[off[0]];
                T0OUT:                  D_OUT = {4'h0, cnt3[0]};
                T1OUT:                  D_OUT = {4'h0, cnt3[1]};
                T2OUT:                  D_OUT = {4'h0, cnt3[2]};
                default:                D_OUT = 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_smp_io_regs.sv
// Bench for smp_io_regs: directed scenarios plus random traffic, every cycle
// compared against an integer-arithmetic model of the register map.
module tb_smp_io_regs;
    localparam int P01 = 4;
    localparam int P2  = 16;

    logic        CLK = 1'b0, RST_N = 1'b0, EN = 1'b0, WE_N = 1'b1, HOST_WR = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_IN = 8'h00, DSP_DIN = 8'h00, HOST_DIN = 8'h00;
    logic [1:0]  HOST_ADDR = 2'd0;
    logic        IO_SEL, IPL_EN, DSP_WE;
    logic [7:0]  D_OUT, DSP_ADDR, DSP_DOUT, HOST_DOUT;

    int nvec = 0, nerr = 0;

    // reference model state
    int m_p01, m_p2, m_c2[3], m_c3[3], m_tdiv[3], m_cpui[4], m_cpuo[4], m_aux[2];
    int m_dsp_addr, m_dsp_dout;
    bit m_ten[3], m_ipl, m_dsp_we;

    smp_io_regs #(.T01_DIV(P01), .T2_DIV(P2)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .A(A), .D_IN(D_IN), .WE_N(WE_N),
        .IO_SEL(IO_SEL), .D_OUT(D_OUT), .IPL_EN(IPL_EN), .DSP_ADDR(DSP_ADDR),
        .DSP_DIN(DSP_DIN), .DSP_WE(DSP_WE), .DSP_DOUT(DSP_DOUT),
        .HOST_WR(HOST_WR), .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN),
        .HOST_DOUT(HOST_DOUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_dout();
        int o = int'(A[3:0]);
        if (A[15:4] != 12'h00F) return 0;
        if (o == 2) return m_dsp_addr;
        if (o == 3) return int'(DSP_DIN);
        if (o >= 4 && o <= 7) return m_cpui[o-4];
        if (o == 8 || o == 9) return m_aux[o-8];
        if (o >= 13) return m_c3[o-13];
        return 0;
    endfunction

    task automatic check_outs();
        chk("io_sel", 16'(IO_SEL), 16'(A[15:4] == 12'h00F));
        chk("d_out", 16'(D_OUT), 16'(exp_dout()));
        chk("host_dout", 16'(HOST_DOUT), 16'(m_cpuo[HOST_ADDR]));
        chk("ipl_en", 16'(IPL_EN), 16'(m_ipl));
        chk("dsp_addr", 16'(DSP_ADDR), 16'(m_dsp_addr));
        chk("dsp_dout", 16'(DSP_DOUT), 16'(m_dsp_dout));
        chk("dsp_we", 16'(DSP_WE), 16'(m_dsp_we));
    endtask

    task automatic model_reset();
        m_p01 = 0; m_p2 = 0; m_ipl = 1; m_dsp_addr = 0; m_dsp_dout = 0; m_dsp_we = 0;
        for (int i = 0; i < 3; i++) begin m_c2[i] = 0; m_c3[i] = 0; m_tdiv[i] = 0; m_ten[i] = 0; end
        for (int i = 0; i < 4; i++) begin m_cpui[i] = 0; m_cpuo[i] = 0; end
        m_aux[0] = 0; m_aux[1] = 0;
    endtask

    // Next state from the current inputs; timers see pre-edge enables/limits.
    task automatic model_edge();
        bit wr = EN && !WE_N && A[15:4] == 12'h00F;
        int o = int'(A[3:0]);
        bit t01 = 0, t2 = 0;
        if (EN) begin
            m_p01 = (m_p01 + 1) % P01; t01 = (m_p01 == 0);
            m_p2  = (m_p2 + 1) % P2;   t2  = (m_p2 == 0);
        end
        for (int i = 0; i < 3; i++) begin
            bit tk = (i == 2) ? t2 : t01;
            bit rd = EN && WE_N && A == 16'h00FD + 16'(i);
            if (wr && o == 1 && D_IN[i] && !m_ten[i]) begin
                m_c2[i] = 0; m_c3[i] = 0;
            end else begin
                if (rd) m_c3[i] = 0;
                if (tk && m_ten[i]) begin
                    int lim = (m_tdiv[i] == 0) ? 256 : m_tdiv[i];
                    if (m_c2[i] + 1 == lim) begin
                        m_c2[i] = 0; m_c3[i] = (m_c3[i] + 1) % 16;
                    end else m_c2[i] = (m_c2[i] + 1) % 256;
                end
            end
        end
        m_dsp_we = wr && o == 3;
        if (HOST_WR) m_cpui[HOST_ADDR] = int'(HOST_DIN);
        if (wr) begin
            if (o == 1) begin
                for (int i = 0; i < 3; i++) m_ten[i] = D_IN[i];
                m_ipl = D_IN[7];
                if (D_IN[4]) begin m_cpui[0] = 0; m_cpui[1] = 0; end
                if (D_IN[5]) begin m_cpui[2] = 0; m_cpui[3] = 0; end
            end
            if (o == 2) m_dsp_addr = int'(D_IN);
            if (o == 3) m_dsp_dout = int'(D_IN);
            if (o >= 4 && o <= 7) m_cpuo[o-4] = int'(D_IN);
            if (o == 8 || o == 9) m_aux[o-8] = int'(D_IN);
            if (o >= 10 && o <= 12) m_tdiv[o-10] = int'(D_IN);
        end
    endtask

    // One clock: drive after the falling edge, check, advance model, edge.
    task automatic cyc(input bit en, input logic [15:0] a, input bit we_n,
                       input logic [7:0] din, input int exp, input string tag);
        EN = en; A = a; WE_N = we_n; D_IN = din; DSP_DIN = 8'($urandom);
        #1;
        check_outs();
        if (exp >= 0) chk(tag, 16'(D_OUT), 16'(exp));
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
        HOST_WR = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1, a, 0, d, -1, "");
    endtask

    task automatic rd(input logic [15:0] a, input int exp, input string tag);
        cyc(1, a, 1, 8'h00, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1, 16'h0000, 1, 8'h00, -1, "");
    endtask

    task automatic do_reset();
        EN = 0; WE_N = 1; A = 16'h0000; HOST_WR = 0;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outs();
        #2 RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic wait_tick2_edge();
        int k = 0;
        while (m_p2 != P2 - 1 && k < 2 * P2) begin idle(1); k++; end
        chk("tick_align", 16'(m_p2), 16'(P2 - 1));
    endtask

    initial begin
        @(negedge CLK);
        do_reset();

        // reset readback and IPL enable
        rd(16'h00F1, 0, "rd_f1_rst");
        rd(16'h00F4, 0, "rd_f4_rst");
        rd(16'h00FD, 0, "rd_fd_rst");
        chk("ipl_rst", 16'(IPL_EN), 16'd1);
        wr(16'h00F1, 8'h00);
        chk("ipl_off", 16'(IPL_EN), 16'd0);

        // timer 2, limit 4, four ticks
        wr(16'h00FC, 8'd4);
        wr(16'h00F1, 8'h04);
        idle(64);
        rd(16'h00FF, 1, "t2_cnt");
        rd(16'h00FF, 0, "t2_clr");

        // timer 0, limit 256, stage 3 wraps through 16
        do_reset();
        wr(16'h00F1, 8'h01);
        idle(P01 * 256 * 17);
        rd(16'h00FD, 1, "t0_wrap");

        // read-clear on the same edge as a stage-3 increment
        do_reset();
        wr(16'h00FC, 8'd1);
        wr(16'h00F1, 8'h04);
        wait_tick2_edge();
        rd(16'h00FF, -1, "");
        rd(16'h00FF, 1, "clr_vs_inc");

        // enable 0->1 coinciding with a tick zeroes cnt2 (left at 1) and cnt3
        wr(16'h00FC, 8'd2);
        idle(P2);
        wr(16'h00F1, 8'h00);
        wait_tick2_edge();
        wr(16'h00F1, 8'h04);
        rd(16'h00FF, 0, "restart_cnt3");
        idle(3 * P2);
        rd(16'h00FF, 1, "restart_cnt2");

        // host mailbox (host side not gated by EN)
        HOST_WR = 1; HOST_ADDR = 2'd1; HOST_DIN = 8'hAA;
        cyc(0, 16'h0000, 1, 8'h00, -1, "");
        rd(16'h00F5, 8'hAA, "host_aa");
        HOST_WR = 1; HOST_ADDR = 2'd0; HOST_DIN = 8'h55;
        wr(16'h00F1, 8'h10);
        rd(16'h00F4, 0, "clr_wins");
        rd(16'h00F5, 0, "clr_p1");
        wr(16'h00F6, 8'h3C);
        HOST_ADDR = 2'd2;
        #1 chk("host_dout", 16'(HOST_DOUT), 16'h003C);

        // DSP window
        wr(16'h00F2, 8'h4C);
        wr(16'h00F3, 8'h01);
        chk("dsp_we_hi", 16'(DSP_WE), 16'd1);
        chk("dsp_dout", 16'(DSP_DOUT), 16'h0001);
        chk("dsp_addr", 16'(DSP_ADDR), 16'h004C);
        idle(1);
        chk("dsp_we_lo", 16'(DSP_WE), 16'd0);
        cyc(0, 16'h00F3, 0, 8'h99, -1, "");
        chk("dsp_we_noen", 16'(DSP_WE), 16'd0);
        chk("dsp_dout_noen", 16'(DSP_DOUT), 16'h0001);

        // reset in the middle of a DSP write pulse
        wr(16'h00F3, 8'h77);
        chk("dsp_we_pre", 16'(DSP_WE), 16'd1);
        do_reset();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            a = ($urandom_range(0, 4) != 0) ? {12'h00F, 4'($urandom)} : 16'($urandom);
            d = 8'($urandom);
            if (a[15:4] == 12'h00F && a[3:0] >= 4'hA && a[3:0] <= 4'hC)
                d = 8'($urandom_range(0, 3));
            HOST_WR = ($urandom_range(0, 3) == 0);
            HOST_ADDR = 2'($urandom);
            HOST_DIN = 8'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, a, 1'($urandom), d, -1, "");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/smp_io_regs.md
Name: smp_io_regs

Overview:
- Memory-mapped I/O block for the SPC700 CPU, covering $00F0-$00FF.
- Sits directly downstream of the CPU address/data/write-enable outputs and feeds read data back into the CPU data-in mux.
- Implements the CONTROL register, the DSP address/data window, the four host mailbox ports in each direction, two auxiliary bytes and the three prescaled timers with read-to-clear 4-bit counters.
- Also produces the IPL ROM enable consumed by the memory mux.

Parameters:
- T01_DIV, 128: CPU enable cycles per stage-1 tick for timers 0 and 1.
- T2_DIV, 16: CPU enable cycles per stage-1 tick for timer 2.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  CPU cycle enable; all CPU-side state changes and prescalers advance only when EN=1
- A  in  16  CPU address
- D_IN  in  8  CPU write data
- WE_N  in  1  CPU write strobe, active low, qualified by EN
- IO_SEL  out  1  comb: A[15:4]==12'h00F
- D_OUT  out  8  comb read data; 8'h00 when IO_SEL=0
- IPL_EN  out  1  CONTROL[7]
- DSP_ADDR  out  8  $F2 register
- DSP_DIN  in  8  DSP read data, returned on $F3 reads
- DSP_WE  out  1  one-CLK pulse on an EN-qualified write to $F3
- DSP_DOUT  out  8  data for DSP_WE
- HOST_WR  in  1  host write to CPUI[HOST_ADDR], not EN-qualified
- HOST_ADDR  in  2  host port index
- HOST_DIN  in  8  host write data
- HOST_DOUT  out  8  comb CPUO[HOST_ADDR]

Behaviour:
- Reset values:
  - CONTROL=8'h80, so IPL_EN=1.
  - DSP_ADDR=0, DSP_DOUT=0, DSP_WE=0.
  - CPUI/CPUO=0, AUX0/AUX1=0.
  - TnDIV=0, prescalers=0, stage-2 counters=0, stage-3 counters=0.
- CPU write event: EN & ~WE_N & IO_SEL, applied on that clock edge.
  - $F0 ignored.
  - $F1 CONTROL:
    - bits 0-2 enable timers 0-2.
    - bit 4=1 clears CPUI0/1 this cycle; bit 5=1 clears CPUI2/3 this cycle. Bits 4/5 are not stored.
    - bit 7 sets IPL_EN.
    - An enable bit going 0->1 zeros that timer's stage-2 and stage-3 counters.
  - $F2 sets DSP_ADDR.
  - $F3 sets DSP_DOUT and pulses DSP_WE.
  - $F4-$F7 set CPUO0-3.
  - $F8/$F9 set AUX0/1.
  - $FA-$FC set T0DIV-T2DIV.
  - $FD-$FF ignored.
- CPU read (comb D_OUT):
  - $F0, $F1, $FA-$FC read 0.
  - $F2 returns DSP_ADDR; $F3 returns DSP_DIN.
  - $F4-$F7 return CPUI0-3.
  - $F8/$F9 return AUX0/1.
  - $FD-$FF return {4'h0, stage-3 counter}.
- Read-clear: EN & WE_N & A==$FD/$FE/$FF zeros that stage-3 counter at the clock edge. D_OUT already showed the pre-clear value.
- Prescalers:
  - Free-running modulo-T01_DIV and modulo-T2_DIV counters that advance on EN.
  - tick01 fires when the counter wraps to 0; tick2 likewise.
  - Prescalers run regardless of timer enables.
- Stage 2, per timer: on tick with enable=1, cnt2 increments (8-bit). When the new value equals TnDIV (TnDIV=0 is treated as 256), cnt2 becomes 0 and stage 3 increments.
- Stage 3: 4-bit counter, wraps 15->0.
- Simultaneous events:
  - Read-clear and a stage-3 increment on the same edge: result is 1 (no lost tick).
  - Enable 0->1 and a tick on the same edge: reset wins, result 0.
  - Host write and a CONTROL clear of the same port on the same edge: clear wins.
  - Writing TnDIV mid-count does not reset cnt2. The compare uses the new value from the next edge; if cnt2 has already passed it, it counts on through the 8-bit wrap.
- DSP_WE: deasserts the cycle after any write; never asserted without EN.
- Reset mid-operation: all state returns to reset values asynchronously; DSP_WE drops immediately.

Decomposition:
- Package smp_io_pkg holds:
  - register offset localparams (CTRL=4'h1 … T2OUT=4'hF);
  - CONTROL bit positions;
  - a timer_state_t struct {cnt2[7:0], cnt3[3:0]}.
- One sub-module, smp_timer, instantiated three times with inputs (tick, en, div, rd_clr, restart) and output cnt3.

Test Plan:
- Reset, then read $F1/$F4/$FD -> 8'h00 each; IPL_EN=1. Write $F1=8'h00 -> IPL_EN=0.
- T2DIV=4, CONTROL=8'h04, run 64 EN cycles (4 ticks) -> $FF reads 1. After that read, the next read of $FF gives 0.
- T0DIV=0 (256), CONTROL=8'h01, run 128*256*17 EN cycles -> $FD reads 1 (stage 3 wrapped 15->0->1).
- Arrange a $FF read-clear on the exact edge of a stage-3 increment -> the next read returns 1. Repeat with CONTROL 0->1 coinciding with a tick -> cnt2=0, cnt3=0.
- Host write CPUI1=8'hAA; CPU reads $F5 -> 8'hAA. CPU writes $F1=8'h10 in the same cycle as HOST_WR CPUI0=8'h55 -> $F4 reads 8'h00 and $F5 reads 8'h00. CPU writes $F6=8'h3C -> HOST_DOUT=8'h3C at HOST_ADDR=2.
- Write $F2=8'h4C, then $F3=8'h01 -> DSP_WE high exactly one cycle, with DSP_DOUT=8'h01 and DSP_ADDR=8'h4C. Hold EN=0 during a write attempt -> no pulse.
